// File: rtl/key_repeat_queue_pkg.sv
// key_repeat_queue_pkg
// Shared keyboard definitions used by the key repeat queue and its bench:
// the system clock frequency, the default typematic delay/rate in clock
// cycles, the repeat FSM state encoding and a small constant helper.
// No ports (package).

package key_repeat_queue_pkg;

  // System clock driving the keyboard logic.
  localparam int CLK_FREQ_HZ = 25_125_000;

  // 500 us to the first repeat, then one repeat every 100 us at CLK_FREQ_HZ.
  localparam int DEFAULT_DELAY_CYCLES = 12563;
  localparam int DEFAULT_RATE_CYCLES  = 2513;

  // Repeat FSM: IDLE (no key), DELAY (waiting for first repeat),
  // REPEAT (emitting at the repeat rate).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } repeatState_t;

  // Larger of two integers, used to size the shared delay/rate timer.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeat_queue_fifo.sv
// sync_fifo
// Single-clock first-word fall-through FIFO holding queued key codes.
// A pop is honoured only when the FIFO is non-empty; a push is accepted when
// there is room, or when a same-edge pop frees an entry while full.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (pointers and count only)
//   push   in   write din this edge
//   pop    in   advance the head this edge
//   din    in   WIDTH-bit write data
//   dout   out  head entry, 0 when empty
//   count  out  occupied entries, $clog2(DEPTH)+1 bits
//   full   out  count == DEPTH
//   empty  out  count == 0

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPop;
  logic             w_doPush;

  // Qualify the requests: an empty pop is ignored, and a push while full
  // only fits when the head is leaving on the same edge.
  always_comb begin
    empty    = (r_count == '0);
    full     = (r_count == CNT_MAX);
    w_doPop  = pop && !empty;
    w_doPush = push && (!full || w_doPop);
    count    = r_count;
    dout     = empty ? '0 : r_mem[r_rdPtr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

endmodule

// File: rtl/key_repeat_queue.sv
// key_repeat_queue
// Turns a level key code into a stream of typematic key events: one entry on
// the press, another DELAY_CYCLES later, then one every RATE_CYCLES while the
// key stays down. Events are queued in a FIFO for a consumer.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   key_in    in   16-bit key code, 0 = no key, held while down
//   pop       in   consumer acknowledges the head entry
//   key_out   out  head entry (fall-through), 0 when empty
//   valid     out  FIFO non-empty
//   count     out  occupied entries
//   overflow  out  sticky: an event was dropped on a full FIFO

module key_repeat_queue
  import key_repeat_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
  parameter int RATE_CYCLES  = DEFAULT_RATE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            key_in,
  input  logic                   pop,
  output logic [15:0]            key_out,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int TIMER_W = $clog2(maxInt(DELAY_CYCLES, RATE_CYCLES)) + 1;
  localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(DELAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(RATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  repeatState_t        r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [15:0]         r_heldKey;
  logic                r_overflow;

  logic                w_press;
  logic                w_delayDone;
  logic                w_rateDone;
  logic                w_push;
  logic [15:0]         w_pushData;
  logic                w_full;
  logic                w_empty;

  // A press (new non-zero key) pushes on the same edge it is seen and wins
  // over any repeat that happens to fall due on that edge.
  always_comb begin
    w_press     = (key_in != 16'h0) && (key_in != r_heldKey);
    w_delayDone = (r_state == ST_DELAY)  && (r_timer == DELAY_LAST);
    w_rateDone  = (r_state == ST_REPEAT) && (r_timer == RATE_LAST);
    w_push      = 1'b0;
    w_pushData  = r_heldKey;
    if (key_in != 16'h0) begin
      if (w_press) begin
        w_push     = 1'b1;
        w_pushData = key_in;
      end else if (w_delayDone || w_rateDone) begin
        w_push = 1'b1;
      end
    end
  end

  // Repeat FSM and timer. Releasing the key returns to IDLE immediately;
  // the timer is cleared on every push so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_heldKey <= 16'h0;
    end else if (key_in == 16'h0) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_heldKey <= 16'h0;
    end else if (w_press) begin
      r_state   <= ST_DELAY;
      r_timer   <= '0;
      r_heldKey <= key_in;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (w_delayDone) begin
            r_state <= ST_REPEAT;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        ST_REPEAT: begin
          if (w_rateDone) r_timer <= '0;
          else            r_timer <= r_timer + TIMER_ONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  // A push is lost only when full with no pop on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n)                          r_overflow <= 1'b0;
    else if (w_push && w_full && !pop)   r_overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (pop),
    .din   (w_pushData),
    .dout  (key_out),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign valid    = !w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_key_repeat_queue.sv
// tb_key_repeat_queue
// Bench for key_repeat_queue with DEPTH=4, DELAY_CYCLES=10, RATE_CYCLES=4.
// A queue-based reference model predicts the outputs every cycle from the
// typematic rules (press age arithmetic), directed scenarios pin known
// literal values, and a randomized phase exercises keys, pops and resets.

module tb_key_repeat_queue;

  localparam int DEPTH = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] key_in = 16'h0;
  logic        pop = 1'b0;
  logic [15:0] key_out;
  logic        valid;
  logic [2:0]  count;
  logic        overflow;

  int compared = 0;
  int mismatched = 0;

  key_repeat_queue #(
    .DEPTH        (DEPTH),
    .DELAY_CYCLES (DELAY),
    .RATE_CYCLES  (RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .pop      (pop),
    .key_out  (key_out),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] mQ[$];
  logic [15:0] mHeld = 16'h0;
  bit          mActive = 0;
  int          mAge = 0;
  bit          mOverflow = 0;
  bit          modelReady = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input logic p, input int n);
    key_in = k;
    pop    = p;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(16'h0, 1'b0, 1);
    rst_n = 1'b1;
  endtask

  // Model: a held key emits at age 0, at age DELAY, then every RATE after.
  always @(posedge clk) begin
    bit          doPush;
    logic [15:0] pData;
    int          preSize;
    bit          popEff;
    doPush = 0;
    pData  = 16'h0;
    if (!rst_n) begin
      mQ.delete();
      mHeld      = 16'h0;
      mActive    = 0;
      mAge       = 0;
      mOverflow  = 0;
      modelReady = 1;
    end else begin
      if (key_in == 16'h0) begin
        mHeld   = 16'h0;
        mActive = 0;
      end else if (key_in != mHeld) begin
        mHeld   = key_in;
        mActive = 1;
        mAge    = 0;
        doPush  = 1;
        pData   = key_in;
      end else if (mActive) begin
        mAge++;
        if (mAge == DELAY || (mAge > DELAY && ((mAge - DELAY) % RATE) == 0)) begin
          doPush = 1;
          pData  = mHeld;
        end
      end
      preSize = mQ.size();
      popEff  = pop && (preSize > 0);
      if (popEff) void'(mQ.pop_front());
      if (doPush) begin
        if (preSize < DEPTH || popEff) mQ.push_back(pData);
        else mOverflow = 1;
      end
    end
  end

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("model key_out", {16'h0, key_out}, {16'h0, (mQ.size() > 0) ? mQ[0] : 16'h0});
      checkOutput("model valid", {31'h0, valid}, {31'h0, (mQ.size() > 0)});
      checkOutput("model count", {29'h0, count}, mQ.size());
      checkOutput("model overflow", {31'h0, overflow}, {31'h0, mOverflow});
    end
  end

  logic [15:0] keyList [4] = '{16'h0000, 16'h0061, 16'h0062, 16'h0082};
  logic [15:0] curKey = 16'h0;

  initial begin
    $display("[TB] start");
    applyStimulus(16'h0, 1'b0, 2);
    rst_n = 1'b1;
    checkOutput("reset count", {29'h0, count}, 0);
    checkOutput("reset valid", {31'h0, valid}, 0);
    checkOutput("reset key_out", {16'h0, key_out}, 0);
    checkOutput("reset overflow", {31'h0, overflow}, 0);

    // Long hold: six events, two dropped at depth 4
    resetDut();
    applyStimulus(16'h0061, 1'b0, 30);
    checkOutput("hold30 count", {29'h0, count}, 4);
    checkOutput("hold30 overflow", {31'h0, overflow}, 1);
    checkOutput("hold30 head", {16'h0, key_out}, 32'h61);
    applyStimulus(16'h0, 1'b0, 2);

    // Short press gives exactly one entry; valid drops after the pop
    resetDut();
    applyStimulus(16'h0061, 1'b0, 3);
    applyStimulus(16'h0, 1'b0, 2);
    checkOutput("short count", {29'h0, count}, 1);
    checkOutput("short head", {16'h0, key_out}, 32'h61);
    applyStimulus(16'h0, 1'b1, 1);
    checkOutput("short valid after pop", {31'h0, valid}, 0);
    checkOutput("short count after pop", {29'h0, count}, 0);

    // Key change while repeating restarts the delay for the new key
    resetDut();
    applyStimulus(16'h0061, 1'b0, 12);
    applyStimulus(16'h0062, 1'b0, 1);
    checkOutput("change count", {29'h0, count}, 3);
    applyStimulus(16'h0062, 1'b0, 9);
    checkOutput("change no early repeat", {29'h0, count}, 3);
    applyStimulus(16'h0062, 1'b0, 1);
    checkOutput("change repeat arrives", {29'h0, count}, 4);
    checkOutput("change head0", {16'h0, key_out}, 32'h61);
    applyStimulus(16'h0, 1'b1, 1);
    checkOutput("change head1", {16'h0, key_out}, 32'h61);
    applyStimulus(16'h0, 1'b1, 1);
    checkOutput("change head2", {16'h0, key_out}, 32'h62);
    applyStimulus(16'h0, 1'b1, 1);
    checkOutput("change head3", {16'h0, key_out}, 32'h62);
    applyStimulus(16'h0, 1'b1, 1);
    checkOutput("change drained", {31'h0, valid}, 0);

    // Full FIFO with repeat push and pop on the same edge
    resetDut();
    applyStimulus(16'h0063, 1'b0, 1);
    applyStimulus(16'h0061, 1'b0, 18);
    checkOutput("full count", {29'h0, count}, 4);
    checkOutput("full head", {16'h0, key_out}, 32'h63);
    applyStimulus(16'h0061, 1'b1, 1);
    checkOutput("full+pop count", {29'h0, count}, 4);
    checkOutput("full+pop overflow", {31'h0, overflow}, 0);
    checkOutput("full+pop head", {16'h0, key_out}, 32'h61);
    applyStimulus(16'h0, 1'b0, 1);

    // Reset mid-hold flushes the queue; held key presses again afterwards
    resetDut();
    applyStimulus(16'h0082, 1'b0, 15);
    checkOutput("midhold count", {29'h0, count}, 3);
    rst_n = 1'b0;
    applyStimulus(16'h0082, 1'b0, 1);
    checkOutput("midhold reset count", {29'h0, count}, 0);
    checkOutput("midhold reset valid", {31'h0, valid}, 0);
    rst_n = 1'b1;
    applyStimulus(16'h0082, 1'b0, 1);
    checkOutput("midhold repress count", {29'h0, count}, 1);
    checkOutput("midhold repress head", {16'h0, key_out}, 32'h82);

    // Pop on an empty FIFO is ignored
    resetDut();
    applyStimulus(16'h0, 1'b1, 5);
    checkOutput("empty pop count", {29'h0, count}, 0);
    applyStimulus(16'h0044, 1'b0, 1);
    applyStimulus(16'h0, 1'b0, 1);
    checkOutput("empty pop then push count", {29'h0, count}, 1);
    checkOutput("empty pop then push head", {16'h0, key_out}, 32'h44);

    // Randomized keys, pops and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) curKey = keyList[$urandom_range(0, 3)];
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      applyStimulus(curKey, ($urandom_range(0, 3) == 0), 1);
    end
    rst_n = 1'b1;
    applyStimulus(16'h0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
